// File: rtl/arb_pkg.sv
// Shared types and helpers for the 4-way round-robin arbiter: sizes, FSM
// state encoding and the rotate-priority winner search.
package arb_pkg;
  localparam int NREQ = 4;
  localparam int IDXW = 2;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    TURN = 2'b10
  } state_e;

  // First requester at or after ptr, scanning ptr, ptr+1, ... modulo NREQ.
  // The scan runs backwards so that the last hit recorded is the nearest one.
  function automatic logic [IDXW-1:0] rr_winner(input logic [NREQ-1:0] req,
                                               input logic [IDXW-1:0] ptr);
    logic [IDXW-1:0] idx;
    logic [IDXW-1:0] win;
    win = ptr;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = ptr + IDXW'(k);
      if (req[idx]) win = idx;
    end
    return win;
  endfunction
endpackage

// File: rtl/gnt_dec24.sv
// 2-to-4 one-hot decoder with enable; all-zero output when disabled.
module gnt_dec24
  import arb_pkg::*;
(
  input  logic [IDXW-1:0] idx,
  input  logic            en,
  output logic [NREQ-1:0] onehot
);
  always_comb begin
    onehot = '0;
    if (en) onehot[idx] = 1'b1;
  end
endmodule

// File: rtl/rr_arb4_ctrl.sv
// Four-requester round-robin arbiter with a one-cycle turnaround and optional
// hold-timeout preemption. Define RR_ARB4_STATS_EN to add per-requester grant counters.
module rr_arb4_ctrl
  import arb_pkg::*;
#(
  parameter int HOLD_MAX = 8,
  parameter int CNTW     = 4
) (
  input  logic        CLK,
  input  logic        RSTB,
  input  logic [3:0]  REQ,
`ifdef RR_ARB4_STATS_EN
  input  logic        STAT_CLR,
  output logic [31:0] GCNT,
`endif
  output logic [3:0]  GNT,
  output logic [1:0]  GIDX,
  output logic        VALID,
  output logic        PREEMPT,
  output logic [1:0]  STATE_DBG
);
  localparam logic [CNTW-1:0] CNT_MAX    = '1;
  localparam logic [CNTW-1:0] HOLD_LAST  = CNTW'((HOLD_MAX > 0) ? HOLD_MAX - 1 : 0);
  localparam bit              PREEMPT_EN = (HOLD_MAX > 0);

  state_e          state_q, state_d;
  logic [IDXW-1:0] ptr_q, ptr_d;
  logic [IDXW-1:0] gidx_q, gidx_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            preempt_q, preempt_d;
  logic [IDXW-1:0] win;
  logic            others_pending;
  logic            enter_busy;

  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    gidx_d         = gidx_q;
    cnt_d          = cnt_q;
    preempt_d      = 1'b0;
    win            = rr_winner(REQ, ptr_q);
    others_pending = |(REQ & ~(NREQ'(1) << gidx_q));
    case (state_q)
      IDLE, TURN: begin
        // TURN sees the pointer already advanced past the previous holder.
        if (|REQ) begin
          state_d = BUSY;
          gidx_d  = win;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        if (!REQ[gidx_q]) begin
          state_d = TURN;
          ptr_d   = gidx_q + 1'b1;
        end else if (PREEMPT_EN && (cnt_q == HOLD_LAST) && others_pending) begin
          state_d   = TURN;
          ptr_d     = gidx_q + 1'b1;
          preempt_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    enter_busy = (state_q != BUSY) && (state_d == BUSY);
  end

`ifdef RR_ARB4_STATS_EN
  logic [3:0][7:0] gcnt_q, gcnt_d;

  always_comb begin
    gcnt_d = gcnt_q;
    if (STAT_CLR) begin
      gcnt_d = '0;
    end else if (enter_busy && (gcnt_q[gidx_d] != 8'hFF)) begin
      gcnt_d[gidx_d] = gcnt_q[gidx_d] + 8'd1;
    end
  end

  assign GCNT = gcnt_q;
`else
  logic unused_enter_busy;
  assign unused_enter_busy = enter_busy;
`endif

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      gidx_q    <= '0;
      cnt_q     <= '0;
      preempt_q <= 1'b0;
`ifdef RR_ARB4_STATS_EN
      gcnt_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gidx_q    <= gidx_d;
      cnt_q     <= cnt_d;
      preempt_q <= preempt_d;
`ifdef RR_ARB4_STATS_EN
      gcnt_q    <= gcnt_d;
`endif
    end
  end

  // PREEMPT is registered, so its pulse lands on the TURN cycle that follows the timeout.
  assign GIDX      = gidx_q;
  assign VALID     = (state_q == BUSY);
  assign PREEMPT   = preempt_q;
  assign STATE_DBG = state_q;

  gnt_dec24 u_dec (
    .idx    (gidx_q),
    .en     (VALID),
    .onehot (GNT)
  );
endmodule

// File: tb/tb_rr_arb4_ctrl.sv
// Directed bench for rr_arb4_ctrl: reset, single grant, rotation, wrap,
// preemption and (with RR_ARB4_STATS_EN) grant statistics.
module tb_rr_arb4_ctrl;
  logic        CLK = 1'b0;
  logic        RSTB = 1'b0;
  logic [3:0]  REQ = 4'b0000;
  logic [3:0]  GNT;
  logic [1:0]  GIDX;
  logic        VALID;
  logic        PREEMPT;
  logic [1:0]  STATE_DBG;
`ifdef RR_ARB4_STATS_EN
  logic        STAT_CLR = 1'b0;
  logic [31:0] GCNT;
`endif

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  rr_arb4_ctrl #(.HOLD_MAX(8), .CNTW(4)) dut (
    .CLK       (CLK),
    .RSTB      (RSTB),
    .REQ       (REQ),
`ifdef RR_ARB4_STATS_EN
    .STAT_CLR  (STAT_CLR),
    .GCNT      (GCNT),
`endif
    .GNT       (GNT),
    .GIDX      (GIDX),
    .VALID     (VALID),
    .PREEMPT   (PREEMPT),
    .STATE_DBG (STATE_DBG)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    REQ  = 4'b0000;
    RSTB = 1'b0;
    tick();
    tick();
    RSTB = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (GNT !== 4'b0000) begin errors++; $display("FAIL reset_gnt got %b want 0000", GNT); end
    checks++; if (VALID !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", VALID); end
    checks++; if (GIDX !== 2'd0) begin errors++; $display("FAIL reset_gidx got %0d want 0", GIDX); end
    checks++; if (PREEMPT !== 1'b0) begin errors++; $display("FAIL reset_preempt got %b want 0", PREEMPT); end
    checks++; if (STATE_DBG !== 2'b00) begin errors++; $display("FAIL reset_state got %b want 00", STATE_DBG); end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    REQ = 4'b0100;
    tick();
    tick();
    tick();
    checks++; if (GNT !== 4'b0100) begin errors++; $display("FAIL midrst_pre_gnt got %b want 0100", GNT); end
    #2 RSTB = 1'b0;
    #1;
    checks++; if (GNT !== 4'b0000) begin errors++; $display("FAIL midrst_gnt got %b want 0000", GNT); end
    checks++; if (VALID !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b want 0", VALID); end
    REQ = 4'b0000;
    tick();
    tick();
    RSTB = 1'b1;
    tick();
    tick();
    checks++; if (STATE_DBG !== 2'b00) begin errors++; $display("FAIL midrst_idle got %b want 00", STATE_DBG); end
    checks++; if (GIDX !== 2'd0) begin errors++; $display("FAIL midrst_gidx got %0d want 0", GIDX); end
    checks++; if (VALID !== 1'b0) begin errors++; $display("FAIL midrst_valid_after got %b want 0", VALID); end
  endtask

  task automatic test_single();
    do_reset();
    REQ = 4'b0010;
    tick();
    checks++; if (GNT !== 4'b0010) begin errors++; $display("FAIL single_gnt got %b want 0010", GNT); end
    checks++; if (GIDX !== 2'd1) begin errors++; $display("FAIL single_gidx got %0d want 1", GIDX); end
    checks++; if (VALID !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", VALID); end
    tick();
    tick();
    tick();
    REQ = 4'b0000;
    checks++; if (GNT !== 4'b0010) begin errors++; $display("FAIL single_hold got %b want 0010", GNT); end
    tick();
    checks++; if (STATE_DBG !== 2'b10) begin errors++; $display("FAIL single_turn got %b want 10", STATE_DBG); end
    checks++; if (GNT !== 4'b0000) begin errors++; $display("FAIL single_turn_gnt got %b want 0000", GNT); end
    tick();
    checks++; if (STATE_DBG !== 2'b00) begin errors++; $display("FAIL single_idle got %b want 00", STATE_DBG); end
    checks++; if (GIDX !== 2'd1) begin errors++; $display("FAIL single_gidx_hold got %0d want 1", GIDX); end
  endtask

  task automatic test_rotation();
    logic [1:0] order [5];
    logic [3:0] exp_gnt;
    order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    REQ = 4'b1111;
    tick();
    for (int k = 0; k < 5; k++) begin
      exp_gnt = 4'b0001 << order[k];
      checks++; if (GIDX !== order[k]) begin errors++; $display("FAIL rot_gidx step %0d got %0d want %0d", k, GIDX, order[k]); end
      checks++; if (GNT !== exp_gnt) begin errors++; $display("FAIL rot_gnt1 step %0d got %b want %b", k, GNT, exp_gnt); end
      tick();
      checks++; if (GNT !== exp_gnt) begin errors++; $display("FAIL rot_gnt2 step %0d got %b want %b", k, GNT, exp_gnt); end
      REQ[order[k]] = 1'b0;
      tick();
      checks++; if (GNT !== 4'b0000 || VALID !== 1'b0) begin
        errors++; $display("FAIL rot_gap step %0d got gnt %b valid %b want 0000/0", k, GNT, VALID);
      end
      REQ = 4'b1111;
      tick();
    end
    REQ = 4'b0000;
  endtask

  task automatic test_wrap();
    do_reset();
    REQ = 4'b0100;
    tick();
    checks++; if (GIDX !== 2'd2) begin errors++; $display("FAIL wrap_serve2 got %0d want 2", GIDX); end
    REQ = 4'b0000;
    tick();
    tick();
    REQ = 4'b1001;
    tick();
    checks++; if (GNT !== 4'b1000) begin errors++; $display("FAIL wrap_gnt3 got %b want 1000", GNT); end
    REQ = 4'b0001;
    tick();
    checks++; if (GNT !== 4'b0000) begin errors++; $display("FAIL wrap_gap got %b want 0000", GNT); end
    tick();
    checks++; if (GNT !== 4'b0001) begin errors++; $display("FAIL wrap_gnt0 got %b want 0001", GNT); end
    REQ = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_preempt();
    do_reset();
    REQ = 4'b0001;
    tick();
    tick();
    REQ = 4'b0101;
    for (int c = 2; c <= 8; c++) begin
      checks++; if (GNT !== 4'b0001 || PREEMPT !== 1'b0) begin
        errors++; $display("FAIL preempt_hold cycle %0d got gnt %b pre %b want 0001/0", c, GNT, PREEMPT);
      end
      tick();
    end
    checks++; if (PREEMPT !== 1'b1) begin errors++; $display("FAIL preempt_pulse got %b want 1", PREEMPT); end
    checks++; if (GNT !== 4'b0000 || STATE_DBG !== 2'b10) begin
      errors++; $display("FAIL preempt_turn got gnt %b state %b want 0000/10", GNT, STATE_DBG);
    end
    tick();
    checks++; if (GNT !== 4'b0100) begin errors++; $display("FAIL preempt_next got %b want 0100", GNT); end
    checks++; if (PREEMPT !== 1'b0) begin errors++; $display("FAIL preempt_clear got %b want 0", PREEMPT); end
  endtask

  task automatic test_lone_no_preempt();
    do_reset();
    REQ = 4'b0001;
    tick();
    for (int c = 0; c < 20; c++) begin
      checks++; if (GNT !== 4'b0001 || PREEMPT !== 1'b0) begin
        errors++; $display("FAIL lone_hold cycle %0d got gnt %b pre %b want 0001/0", c, GNT, PREEMPT);
      end
      tick();
    end
    REQ = 4'b0000;
  endtask

`ifdef RR_ARB4_STATS_EN
  task automatic test_stats();
    do_reset();
    checks++; if (GCNT !== 32'h0) begin errors++; $display("FAIL stats_reset got %h want 0", GCNT); end
    for (int g = 0; g < 300; g++) begin
      REQ = 4'b0010;
      tick();
      REQ = 4'b0000;
      tick();
      if (g == 2) begin
        checks++; if (GCNT !== 32'h0000_0300) begin errors++; $display("FAIL stats_three got %h want 00000300", GCNT); end
      end
    end
    checks++; if (GCNT !== 32'h0000_FF00) begin errors++; $display("FAIL stats_sat got %h want 0000ff00", GCNT); end
    STAT_CLR = 1'b1;
    tick();
    STAT_CLR = 1'b0;
    checks++; if (GCNT !== 32'h0) begin errors++; $display("FAIL stats_clr got %h want 0", GCNT); end
  endtask
`endif

  initial begin
    test_reset();
    test_reset_mid_grant();
    test_single();
    test_rotation();
    test_wrap();
    test_preempt();
    test_lone_no_preempt();
`ifdef RR_ARB4_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
